reset_sequencer: RTL and testbench

//  Generates the reset network consumed by always_ff blocks: async-assert/sync-deassert resets, released in staged order.

---
 rtl/reset_sequencer.sv | 155 +++++++++++++++
 tb/tb_reset_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset generator: async-assert / sync-deassert, hold, then per-output staged release.
// Optional software reset path enabled by defining RESET_SEQUENCER_SW_REQ_EN.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_OUTPUTS = 3,
    parameter int STAGE_GAP   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_sw_req,
    output logic                   o_sw_ack,
    output logic [NUM_OUTPUTS-1:0] o_rst_n,
    output logic                   o_rst_h,
    output logic                   o_busy,
    output logic [1:0]             o_state
);

    localparam int REL_LAST = (NUM_OUTPUTS - 1) * STAGE_GAP;
    localparam int CNT_MAX  = (HOLD_CYCLES > REL_LAST + 1) ? HOLD_CYCLES : REL_LAST + 1;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [NUM_OUTPUTS-1:0] rst_n_reg;
    logic                   rst_h_reg;
    logic                   busy_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;
    logic [NUM_OUTPUTS-1:0] stage_hit;
    logic                   last_hit;
    logic                   sw_restart;

    // Deassert synchroniser: the board reset clears it asynchronously, ones shift in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

    generate
        for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_stage
            assign stage_hit[gi] = (cnt_reg == CNT_W'(gi * STAGE_GAP));
        end
    endgenerate

    assign last_hit = stage_hit[NUM_OUTPUTS-1];

`ifdef RESET_SEQUENCER_SW_REQ_EN
    logic sw_flag_reg;
    logic sw_ack_reg;

    assign sw_restart = (state_reg == ST_RUN) && i_sw_req;

    // Remembers that the running sequence was software-initiated so completion can be acked.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_flag_reg <= 1'b0;
            sw_ack_reg  <= 1'b0;
        end else begin
            sw_ack_reg <= 1'b0;
            if (sw_restart) begin
                sw_flag_reg <= 1'b1;
            end else if (state_reg == ST_RELEASE && last_hit) begin
                sw_ack_reg  <= sw_flag_reg;
                sw_flag_reg <= 1'b0;
            end
        end
    end

    assign o_sw_ack = sw_ack_reg;
`else
    logic sw_req_unused;

    assign sw_req_unused = i_sw_req;
    assign sw_restart    = 1'b0;
    assign o_sw_ack      = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_RESET;
            cnt_reg   <= '0;
            rst_n_reg <= '0;
            busy_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    if (sync_out) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_reg <= ST_RELEASE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    rst_n_reg <= rst_n_reg | stage_hit;
                    if (last_hit) begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (sw_restart) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= '0;
                        rst_n_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_RESET;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Active-high copy kept as its own flop (async set) so it is never a derived net.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_h_reg <= 1'b1;
        end else if (sw_restart) begin
            rst_h_reg <= 1'b1;
        end else if (state_reg == ST_RELEASE && stage_hit[0]) begin
            rst_h_reg <= 1'b0;
        end
    end

    assign o_rst_n = rst_n_reg;
    assign o_rst_h = rst_h_reg;
    assign o_busy  = busy_reg;
    assign o_state = state_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (default parameters); exercises the software path
// only when RESET_SEQUENCER_SW_REQ_EN is defined.
module tb_reset_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_sw_req = 1'b0;
    logic       o_sw_ack;
    logic [2:0] o_rst_n;
    logic       o_rst_h;
    logic       o_busy;
    logic [1:0] o_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    reset_sequencer dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_sw_req(i_sw_req),
        .o_sw_ack(o_sw_ack),
        .o_rst_n (o_rst_n),
        .o_rst_h (o_rst_h),
        .o_busy  (o_busy),
        .o_state (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Packed observation: {rst_n[2:0], rst_h, busy, state[1:0], ack}
    function automatic logic [7:0] obs();
        return {o_rst_n, o_rst_h, o_busy, o_state, o_sw_ack};
    endfunction

    // Expected outputs t edges after HOLD entry (t<0: still waiting on synchroniser).
    // Release edges: [0] t=17, [1] t=21, [2] t=25 (RUN entry), HOLD->RELEASE at t=16.
    function automatic logic [7:0] exp_vec(input int t, input bit sw);
        logic [2:0] r;
        logic [1:0] s;
        r[0] = (t >= 17);
        r[1] = (t >= 21);
        r[2] = (t >= 25);
        if (t < 0)       s = 2'd0;
        else if (t < 16) s = 2'd1;
        else if (t < 25) s = 2'd2;
        else             s = 2'd3;
        return {r, ~r[0], ~r[2], s, (sw && t == 25)};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        i_rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vec_cnt++;
            if (obs() !== 8'b000_1_1_00_0) begin
                err_cnt++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs(), 8'b000_1_1_00_0);
            end else $display("reset_hold cyc=%0d got=%b ok", i, obs());
        end
        release_reset();
        for (int n = 1; n <= 30; n++) begin
            tick();
            e = exp_vec(n - 3, 1'b0);
            vec_cnt++;
            if (obs() !== e) begin
                err_cnt++;
                $display("FAIL power_on edge=%0d got=%b exp=%b", n, obs(), e);
            end else $display("power_on edge=%0d got=%b ok", n, obs());
        end
    endtask

    task automatic test_async_mid();
        logic [7:0] e;
        i_rst_n = 1'b0;
        tick();
        release_reset();
        for (int n = 1; n <= 22; n++) tick();
        i_rst_n = 1'b0;
        #2;
        vec_cnt++;
        if (obs() !== 8'b000_1_1_00_0) begin
            err_cnt++;
            $display("FAIL async_clear got=%b exp=%b", obs(), 8'b000_1_1_00_0);
        end else $display("async_clear got=%b ok", obs());
        release_reset();
        for (int n = 1; n <= 30; n++) begin
            tick();
            e = exp_vec(n - 3, 1'b0);
            vec_cnt++;
            if (obs() !== e) begin
                err_cnt++;
                $display("FAIL restart edge=%0d got=%b exp=%b", n, obs(), e);
            end else $display("restart edge=%0d got=%b ok", n, obs());
        end
    endtask

    task automatic test_sw_ignored();
        logic [7:0] e;
        i_rst_n = 1'b0;
        tick();
        release_reset();
        for (int n = 1; n <= 30; n++) begin
            if (n == 4) i_sw_req = 1'b1;
            tick();
            if (n == 28) i_sw_req = 1'b0;
            e = exp_vec(n - 3, 1'b0);
            vec_cnt++;
            if (obs() !== e) begin
                err_cnt++;
                $display("FAIL sw_ignored edge=%0d got=%b exp=%b", n, obs(), e);
            end else $display("sw_ignored edge=%0d got=%b ok", n, obs());
        end
    endtask

`ifdef RESET_SEQUENCER_SW_REQ_EN
    task automatic test_sw_req();
        logic [7:0] e;
        tick();
        i_sw_req = 1'b1;
        for (int t = 0; t <= 28; t++) begin
            tick();
            i_sw_req = 1'b0;
            e = exp_vec(t, 1'b1);
            vec_cnt++;
            if (obs() !== e) begin
                err_cnt++;
                $display("FAIL sw_req E+%0d got=%b exp=%b", t, obs(), e);
            end else $display("sw_req E+%0d got=%b ok", t, obs());
        end
    endtask

    task automatic test_sw_held();
        logic [7:0] e;
        i_sw_req = 1'b1;
        for (int n = 0; n < 78; n++) begin
            tick();
            e = exp_vec(n % 26, 1'b1);
            vec_cnt++;
            if (obs() !== e) begin
                err_cnt++;
                $display("FAIL sw_held E+%0d got=%b exp=%b", n, obs(), e);
            end else $display("sw_held E+%0d got=%b ok", n, obs());
        end
        i_sw_req = 1'b0;
    endtask
`else
    task automatic test_sw_disabled();
        for (int n = 0; n < 12; n++) begin
            i_sw_req = n[0];
            tick();
            vec_cnt++;
            if (obs() !== 8'b111_0_0_11_0) begin
                err_cnt++;
                $display("FAIL sw_disabled cyc=%0d got=%b exp=%b", n, obs(), 8'b111_0_0_11_0);
            end else $display("sw_disabled cyc=%0d got=%b ok", n, obs());
        end
        i_sw_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_async_mid();
`ifdef RESET_SEQUENCER_SW_REQ_EN
        test_sw_req();
        test_sw_held();
`else
        test_sw_disabled();
`endif
        test_sw_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
